// File: rtl/gf180mcu_fd_sc_mcu7t5v0__crc8_ser_1_if.sv
// Serial CRC-8 bus: frame control and serial data in, CRC and status out.
// The master modport drives the frame and data bits. The slave modport is
// the CRC engine.
interface gf180mcu_fd_sc_mcu7t5v0__crc8_ser_1_if;
    logic       START;
    logic       EN;
    logic       D;
    logic [7:0] Q;
    logic       BUSY;
    logic       DONE;
    logic       MATCH;

    modport master (
        output START, EN, D,
        input  Q, BUSY, DONE, MATCH
    );

    modport slave (
        input  START, EN, D,
        output Q, BUSY, DONE, MATCH
    );
endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__crc8_ser_1.sv
// Bit-serial CRC-8 accumulator for fixed-length frames, MSB first.
// START (re)loads the register. Each EN-qualified bit in ACC advances the LFSR.
// After NBITS bits, one FIN cycle pulses DONE and latches MATCH (CRC == 0).
module gf180mcu_fd_sc_mcu7t5v0__crc8_ser_1 #(
    parameter logic [7:0] POLY  = 8'h07,
    parameter logic [7:0] INIT  = 8'h00,
    parameter int         NBITS = 16
) (
    input  logic CLK,
    input  logic RN,
    gf180mcu_fd_sc_mcu7t5v0__crc8_ser_1_if.slave bus
);
    // Sized to hold NBITS itself, so the counter never wraps.
    localparam int CW = $clog2(NBITS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(NBITS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [7:0]    crc_reg, crc_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          match_reg, match_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;

    logic          fb;
    logic [7:0]    crc_shift;
    logic [CW-1:0] cnt_inc;

    assign fb      = crc_reg[7] ^ bus.D;
    assign cnt_inc = cnt_reg + CW'(1);

    // One LFSR step: shift left and fold in the polynomial when the feedback bit is set.
    assign crc_shift[0] = fb & POLY[0];
    for (genvar gi = 1; gi < 8; gi++) begin : g_lfsr
        assign crc_shift[gi] = crc_reg[gi-1] ^ (fb & POLY[gi]);
    end

    // Next-state and next-output logic. START overrides everything and drops the coincident bit.
    always_comb begin
        state_next = state_reg;
        crc_next   = crc_reg;
        cnt_next   = cnt_reg;
        match_next = match_reg;
        if (bus.START) begin
            state_next = ACC;
            crc_next   = INIT;
            cnt_next   = '0;
            match_next = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next = IDLE;
                end
                ACC: begin
                    if (bus.EN) begin
                        crc_next = crc_shift;
                        cnt_next = cnt_inc;
                        if (cnt_inc == LAST_CNT) begin
                            state_next = FIN;
                            match_next = (crc_shift == 8'h00);
                        end
                    end
                end
                FIN: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
        busy_next = (state_next == ACC);
        done_next = (state_next == FIN);
    end

    // State and output registers. BUSY and DONE come straight from flops, so they cannot glitch.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_reg <= IDLE;
            crc_reg   <= INIT;
            cnt_reg   <= '0;
            match_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            crc_reg   <= crc_next;
            cnt_reg   <= cnt_next;
            match_reg <= match_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    assign bus.Q     = crc_reg;
    assign bus.BUSY  = busy_reg;
    assign bus.DONE  = done_reg;
    assign bus.MATCH = match_reg;
endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__crc8_ser_1.sv
// Directed bench for the serial CRC-8 block.
// There is one 16-bit-frame instance and one 8-bit-frame instance.
// All expected CRC values are worked out by hand for POLY=07 and INIT=00:
//   0x31           -> 0x97
//   0x31 0x97      -> 0x00
//   first 5 bits of 0x31 -> 0x12
module tb_gf180mcu_fd_sc_mcu7t5v0__crc8_ser_1;
    logic clk;
    logic rn;
    int   total;
    int   bad;

    gf180mcu_fd_sc_mcu7t5v0__crc8_ser_1_if bus16 ();
    gf180mcu_fd_sc_mcu7t5v0__crc8_ser_1_if bus8 ();

    gf180mcu_fd_sc_mcu7t5v0__crc8_ser_1 #(.POLY(8'h07), .INIT(8'h00), .NBITS(16)) dut16 (
        .CLK (clk),
        .RN  (rn),
        .bus (bus16.slave)
    );

    gf180mcu_fd_sc_mcu7t5v0__crc8_ser_1 #(.POLY(8'h07), .INIT(8'h00), .NBITS(8)) dut8 (
        .CLK (clk),
        .RN  (rn),
        .bus (bus8.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Send one byte MSB first to the 16-bit instance, with random EN gaps
    // between bits. DONE may only appear after the final bit of the frame.
    task automatic feed16(input logic [7:0] b, input bit last_byte);
        int gaps;
        for (int i = 7; i >= 0; i--) begin
            gaps = int'($urandom_range(0, 2));
            repeat (gaps) begin
                bus16.EN = 1'b0;
                bus16.D  = 1'($urandom_range(0, 1));
                tick();
                chk("gap_busy", {7'd0, bus16.BUSY}, 8'd1);
                chk("gap_done", {7'd0, bus16.DONE}, 8'd0);
            end
            bus16.EN = 1'b1;
            bus16.D  = b[i];
            tick();
            bus16.EN = 1'b0;
            if (last_byte && i == 0) begin
                chk("frame_done", {7'd0, bus16.DONE}, 8'd1);
                chk("frame_busy", {7'd0, bus16.BUSY}, 8'd0);
            end else begin
                chk("bit_done", {7'd0, bus16.DONE}, 8'd0);
                chk("bit_busy", {7'd0, bus16.BUSY}, 8'd1);
            end
        end
    endtask

    initial begin
        logic [7:0] b8;
        total = 0;
        bad   = 0;
        rn = 1'b1;
        bus16.START = 1'b0; bus16.EN = 1'b0; bus16.D = 1'b0;
        bus8.START  = 1'b0; bus8.EN  = 1'b0; bus8.D  = 1'b0;

        // Reset state, checked before any clock edge.
        #2 rn = 1'b0;
        #1;
        chk("rst_q",     bus16.Q,               8'h00);
        chk("rst_busy",  {7'd0, bus16.BUSY},    8'd0);
        chk("rst_done",  {7'd0, bus16.DONE},    8'd0);
        chk("rst_match", {7'd0, bus16.MATCH},   8'd0);
        chk("rst_q8",    bus8.Q,                8'h00);
        tick();
        rn = 1'b1;

        // START together with EN=1 and D=1 in IDLE: the data bit is dropped.
        // Then send the full frame 31 97 with random gaps.
        bus16.START = 1'b1; bus16.EN = 1'b1; bus16.D = 1'b1;
        tick();
        bus16.START = 1'b0; bus16.EN = 1'b0;
        chk("start_busy", {7'd0, bus16.BUSY}, 8'd1);
        chk("start_q",    bus16.Q,            8'h00);
        feed16(8'h31, 1'b0);
        chk("byte1_q", bus16.Q, 8'h97);
        feed16(8'h97, 1'b1);
        chk("fin_q",     bus16.Q,             8'h00);
        chk("fin_match", {7'd0, bus16.MATCH}, 8'd1);
        tick();
        chk("post_done",  {7'd0, bus16.DONE},  8'd0);
        chk("post_busy",  {7'd0, bus16.BUSY},  8'd0);
        chk("post_match", {7'd0, bus16.MATCH}, 8'd1);

        // IDLE ignores EN and D, and holds Q and MATCH.
        bus16.EN = 1'b1; bus16.D = 1'b1;
        tick();
        tick();
        bus16.EN = 1'b0;
        chk("idle_q",     bus16.Q,             8'h00);
        chk("idle_busy",  {7'd0, bus16.BUSY},  8'd0);
        chk("idle_match", {7'd0, bus16.MATCH}, 8'd1);

        // 8-bit frame with back-to-back bits: 0x31 -> 0x97.
        b8 = 8'h31;
        bus8.START = 1'b1;
        tick();
        bus8.START = 1'b0;
        chk("b8_busy", {7'd0, bus8.BUSY}, 8'd1);
        for (int i = 7; i >= 0; i--) begin
            bus8.EN = 1'b1;
            bus8.D  = b8[i];
            tick();
            if (i > 0) chk("b8_early_done", {7'd0, bus8.DONE}, 8'd0);
        end
        chk("b8_done",  {7'd0, bus8.DONE},  8'd1);
        chk("b8_busyf", {7'd0, bus8.BUSY},  8'd0);
        chk("b8_q",     bus8.Q,             8'h97);
        chk("b8_match", {7'd0, bus8.MATCH}, 8'd0);
        // EN in the FIN cycle is ignored.
        bus8.D = 1'b1;
        tick();
        bus8.EN = 1'b0;
        chk("b8_fin_en_q",    bus8.Q,            8'h97);
        chk("b8_fin_en_done", {7'd0, bus8.DONE}, 8'd0);
        chk("b8_fin_en_busy", {7'd0, bus8.BUSY}, 8'd0);

        // Restart after 7 of 16 bits. DONE waits for 16 new bits.
        bus16.START = 1'b1;
        tick();
        bus16.START = 1'b0;
        b8 = 8'h31;
        for (int i = 7; i >= 1; i--) begin
            bus16.EN = 1'b1;
            bus16.D  = b8[i];
            tick();
            chk("part_done", {7'd0, bus16.DONE}, 8'd0);
        end
        bus16.START = 1'b1; bus16.EN = 1'b1; bus16.D = 1'b1;
        tick();
        bus16.START = 1'b0; bus16.EN = 1'b0;
        chk("restart_q",    bus16.Q,            8'h00);
        chk("restart_busy", {7'd0, bus16.BUSY}, 8'd1);
        feed16(8'h31, 1'b0);
        feed16(8'h97, 1'b1);
        chk("restart_match", {7'd0, bus16.MATCH}, 8'd1);

        // START during FIN: DONE is still high in that cycle, and the next cycle restarts.
        chk("finstart_done", {7'd0, bus16.DONE}, 8'd1);
        bus16.START = 1'b1; bus16.EN = 1'b1; bus16.D = 1'b1;
        tick();
        bus16.START = 1'b0; bus16.EN = 1'b0;
        chk("finstart_busy",  {7'd0, bus16.BUSY},  8'd1);
        chk("finstart_q",     bus16.Q,             8'h00);
        chk("finstart_match", {7'd0, bus16.MATCH}, 8'd0);
        chk("finstart_done2", {7'd0, bus16.DONE},  8'd0);

        // Reset asynchronously in the middle of a frame, after 5 bits.
        b8 = 8'h31;
        for (int i = 7; i >= 3; i--) begin
            bus16.EN = 1'b1;
            bus16.D  = b8[i];
            tick();
        end
        bus16.EN = 1'b0;
        chk("mid_q",    bus16.Q,            8'h12);
        chk("mid_busy", {7'd0, bus16.BUSY}, 8'd1);
        @(posedge clk);
        #2 rn = 1'b0;
        #1;
        chk("arst_q",    bus16.Q,            8'h00);
        chk("arst_busy", {7'd0, bus16.BUSY}, 8'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("arst_nodone", {7'd0, bus16.DONE}, 8'd0);
        end

        // The first edge after reset release handles START as usual.
        @(posedge clk);
        #1;
        rn = 1'b1;
        bus16.START = 1'b1;
        tick();
        bus16.START = 1'b0;
        chk("rel_busy", {7'd0, bus16.BUSY}, 8'd1);
        chk("rel_done", {7'd0, bus16.DONE}, 8'd0);
        feed16(8'h31, 1'b0);
        feed16(8'h97, 1'b1);
        chk("rel_match", {7'd0, bus16.MATCH}, 8'd1);
        chk("rel_q",     bus16.Q,             8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__crc8_ser_1.md
GF180MCU_FD_SC_MCU7T5V0__CRC8_SER_1 -- requirements
Module: gf180mcu_fd_sc_mcu7t5v0__crc8_ser_1

Interface
REQ-001 SHALL provide parameter POLY, default 8'h07, the CRC-8 generator polynomial (x^8 term implicit).
REQ-002 SHALL provide parameter INIT, default 8'h00, the CRC register preload value.
REQ-003 SHALL provide parameter NBITS, default 16, the frame length in bits; legal range 1..1024.
REQ-004 SHALL provide CLK  input  1  the single clock; all state updates on the rising edge.
REQ-005 SHALL provide RN  input  1  reset; asynchronous, active-low.
REQ-006 SHALL provide START  input  1  frame start or restart request.
REQ-007 SHALL provide EN  input  1  serial bit valid qualifier for D.
REQ-008 SHALL provide D  input  1  serial data bit, MSB first.
REQ-009 SHALL provide Q  output  8  CRC register contents.
REQ-010 SHALL provide BUSY  output  1  high while a frame is being accumulated.
REQ-011 SHALL provide DONE  output  1  one-cycle pulse marking frame completion.
REQ-012 SHALL provide MATCH  output  1  final CRC equals 8'h00; valid from the DONE cycle.

Function
REQ-013 SHALL implement states IDLE, ACC and FIN, each with a registered encoding.
REQ-014 IDLE: BUSY=0; EN and D SHALL be ignored; Q and MATCH SHALL hold their values.
REQ-015 START in any state SHALL load Q=INIT, clear the bit counter, clear MATCH and enter ACC on the next edge.
REQ-016 START SHALL take priority over EN in the same cycle; the coincident D bit SHALL be discarded.
REQ-017 ACC with EN=1: fb=Q[7]^D; Q SHALL become {Q[6:0],1'b0} XOR (fb ? POLY : 8'h00).
REQ-018 ACC with EN=1 SHALL also increment the bit counter by 1.
REQ-019 ACC with EN=0 SHALL hold Q and the counter; gaps of any length are legal.
REQ-020 The counter SHALL be wide enough for NBITS without wrap; it SHALL never exceed NBITS.
REQ-021 Accepting the NBITS-th bit SHALL move the state to FIN on that same edge.
REQ-022 FIN SHALL last exactly one cycle, with DONE=1, BUSY=0 and MATCH=(Q==8'h00); the next state SHALL be IDLE.
REQ-023 START during FIN SHALL restart the frame per REQ-015; DONE SHALL still be 1 in that FIN cycle.
REQ-024 EN during FIN SHALL be ignored.
REQ-025 BUSY SHALL be 1 exactly while in ACC.
REQ-026 MATCH SHALL be registered and SHALL hold until the next START or reset.
REQ-027 DONE, BUSY and MATCH SHALL be glitch-free register outputs; Q SHALL drive directly from the CRC register.

Reset
REQ-028 RN low SHALL immediately force state=IDLE, Q=INIT, counter=0, BUSY=0, DONE=0 and MATCH=0, independent of CLK.
REQ-029 RN asserted mid-frame SHALL abandon the frame; no DONE pulse SHALL follow deassertion.
REQ-030 After RN rises, the first active edge SHALL process START normally.

Verification
REQ-031 Reset mid-ACC (after 5 bits) -> Q=8'h00, BUSY=0 at once; no DONE follows.
REQ-032 With NBITS=8, START then byte 8'h31 MSB first with EN=1 every cycle -> DONE pulses one cycle after the 8th bit, Q=8'h97, MATCH=0.
REQ-033 With NBITS=16, bytes 8'h31 then 8'h97 with random EN gaps -> Q=8'h00, DONE=1 for one cycle, MATCH=1, BUSY high for exactly the ACC cycles.
REQ-034 START coincident with EN=1, D=1 in IDLE -> bit discarded, Q=INIT, counter=0.
REQ-035 START asserted after 7 of 16 bits -> frame restarts; DONE occurs only after 16 further accepted bits.
REQ-036 START during the FIN cycle -> DONE=1 that cycle; next cycle BUSY=1, Q=INIT, MATCH=0.
